smu_region_chk: RTL



---
 rtl/smu_region_chk_pkg.sv | 48 ++++
 rtl/smu_region_chk_cmp.sv | 33 +++
 rtl/smu_region_chk.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/smu_region_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smu_pkg
//  Description : Shared constants for the SMU region access-control checker:
//                register offsets, ATTR/CTRL/STATUS bit positions and the
//                AHB HTRANS encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package smu_pkg;

   // Per-region register offsets within a 16-byte region slot
   localparam logic [3:0] c_off_base  = 4'h0;
   localparam logic [3:0] c_off_limit = 4'h4;
   localparam logic [3:0] c_off_attr  = 4'h8;

   // Global register addresses
   localparam logic [7:0] c_addr_ctrl   = 8'h80;
   localparam logic [7:0] c_addr_status = 8'h84;
   localparam logic [7:0] c_addr_vaddr  = 8'h88;

   // ATTR bit positions
   localparam int c_attr_en        = 0;
   localparam int c_attr_rd_deny   = 1;
   localparam int c_attr_wr_deny   = 2;
   localparam int c_attr_priv_only = 3;

   // CTRL bit positions
   localparam int c_ctrl_gen    = 0;
   localparam int c_ctrl_lock   = 1;
   localparam int c_ctrl_int_en = 2;

   // STATUS bit positions
   localparam int c_stat_viol     = 0;
   localparam int c_stat_ovr      = 1;
   localparam int c_stat_vwr      = 2;
   localparam int c_stat_vidx_lsb = 4;

   // AHB HTRANS encodings
   localparam logic [1:0] c_htrans_idle   = 2'b00;
   localparam logic [1:0] c_htrans_busy   = 2'b01;
   localparam logic [1:0] c_htrans_nonseq = 2'b10;
   localparam logic [1:0] c_htrans_seq    = 2'b11;

   // AHB HPROT bit that marks a privileged access
   localparam int c_hprot_priv = 1;

endpackage
`default_nettype wire

// File: rtl/smu_region_chk_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : smu_region_cmp
//  Description : One region window comparator. Reports whether the address
//                field falls inside [base, limit] of an enabled region and
//                which access directions that region denies for this access.
//  Revision    : 1.0 - initial release
// ============================================================================
module smu_region_cmp
   import smu_pkg::*;
#(
   parameter int AW = 22
)(
   input  logic [AW-1:0] addr_field,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] limit,
   input  logic [3:0]    attr,
   input  logic          priv,
   output logic          hit,
   output logic          rd_den,
   output logic          wr_den
);

   logic w_priv_block;

   // Limit is inclusive; an unprivileged access to a PRIV_ONLY region is denied both ways
   assign hit          = attr[c_attr_en] & (addr_field >= base) & (addr_field <= limit);
   assign w_priv_block = attr[c_attr_priv_only] & ~priv;
   assign rd_den       = attr[c_attr_rd_deny] | w_priv_block;
   assign wr_den       = attr[c_attr_wr_deny] | w_priv_block;

endmodule
`default_nettype wire

// File: rtl/smu_region_chk.sv
`default_nettype none
// ============================================================================
//  Module      : smu_region_chk
//  Description : AHB region access-control checker in front of the SRAM bank.
//                Combinational read/write deny flags from REGION_NUM windows
//                (lowest index wins), first-violation capture with overrun,
//                level interrupt, and a single-cycle config register port.
//  Revision    : 1.0 - initial release
// ============================================================================
module smu_region_chk
   import smu_pkg::*;
#(
   parameter int REGION_NUM = 4,
   parameter int GRAN_LSB   = 10
)(
   input  logic        mem_hclk,
   input  logic        mem_hrst_b,
   input  logic        mem_hsel,
   input  logic [31:0] mem_haddr,
   input  logic [1:0]  mem_htrans,
   input  logic        mem_hwrite,
   input  logic [3:0]  mem_hprot,
   input  logic        mem_hready,
   output logic        region_rd_deny_flag,
   output logic        region_wr_deny_flag,
   input  logic        cfg_sel,
   input  logic        cfg_write,
   input  logic [7:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   output logic        cfg_ack,
   output logic        cfg_err,
   output logic        smu_irq
);

   localparam int c_aw = 32 - GRAN_LSB;

   // Configuration state
   logic [c_aw-1:0] r_base  [REGION_NUM];
   logic [c_aw-1:0] r_limit [REGION_NUM];
   logic [3:0]      r_attr  [REGION_NUM];
   logic            r_gen;
   logic            r_lock;
   logic            r_int_en;

   // Violation capture state
   logic            r_viol;
   logic            r_ovr;
   logic            r_vwr;
   logic [2:0]      r_vidx;
   logic [31:0]     r_vaddr;
   logic            r_irq;

   // Config response
   logic            r_ack;
   logic            r_err;
   logic [31:0]     r_rdata;

   // Region comparison results
   logic [REGION_NUM-1:0] w_hit;
   logic [REGION_NUM-1:0] w_rd_den;
   logic [REGION_NUM-1:0] w_wr_den;
   logic                  w_win_hit;
   logic [2:0]            w_win_idx;
   logic                  w_win_rd;
   logic                  w_win_wr;
   logic                  w_viol_ev;

   // Config decode
   logic        w_is_region;
   logic [2:0]  w_ridx;
   logic        w_ridx_ok;
   logic        w_sel_base;
   logic        w_sel_limit;
   logic        w_sel_attr;
   logic        w_sel_region;
   logic        w_sel_ctrl;
   logic        w_sel_status;
   logic        w_sel_vaddr;
   logic        w_mapped;
   logic        w_err;
   logic        w_wr_ok;
   logic        w_w1c_viol;
   logic        w_w1c_ovr;
   logic        w_viol_eff;
   logic [31:0] w_rdata;

   generate
      for (genvar gi = 0; gi < REGION_NUM; gi++) begin : g_region
         smu_region_cmp #(.AW(c_aw)) u_cmp (
            .addr_field (mem_haddr[31:GRAN_LSB]),
            .base       (r_base[gi]),
            .limit      (r_limit[gi]),
            .attr       (r_attr[gi]),
            .priv       (mem_hprot[c_hprot_priv]),
            .hit        (w_hit[gi]),
            .rd_den     (w_rd_den[gi]),
            .wr_den     (w_wr_den[gi])
         );
      end
   endgenerate

   // Priority encoder: scanning downward lets the lowest-index hit overwrite the rest
   always_comb begin
      w_win_hit = 1'b0;
      w_win_idx = 3'd0;
      w_win_rd  = 1'b0;
      w_win_wr  = 1'b0;
      for (int i = REGION_NUM - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_win_hit = 1'b1;
            w_win_idx = i[2:0];
            w_win_rd  = w_rd_den[i];
            w_win_wr  = w_wr_den[i];
         end
      end
   end

   assign region_rd_deny_flag = r_gen & w_win_hit & w_win_rd & ~mem_hwrite;
   assign region_wr_deny_flag = r_gen & w_win_hit & w_win_wr &  mem_hwrite;

   // Only real transfers (NONSEQ/SEQ with hready) are recorded as violations
   assign w_viol_ev = mem_hsel & mem_hready & mem_htrans[1]
                    & (region_rd_deny_flag | region_wr_deny_flag);

   // Register address decode and access legality
   assign w_is_region  = ~cfg_addr[7];
   assign w_ridx       = cfg_addr[6:4];
   assign w_ridx_ok    = ({29'd0, w_ridx} < 32'(REGION_NUM));
   assign w_sel_base   = w_is_region & w_ridx_ok & (cfg_addr[3:0] == c_off_base);
   assign w_sel_limit  = w_is_region & w_ridx_ok & (cfg_addr[3:0] == c_off_limit);
   assign w_sel_attr   = w_is_region & w_ridx_ok & (cfg_addr[3:0] == c_off_attr);
   assign w_sel_region = w_sel_base | w_sel_limit | w_sel_attr;
   assign w_sel_ctrl   = (cfg_addr == c_addr_ctrl);
   assign w_sel_status = (cfg_addr == c_addr_status);
   assign w_sel_vaddr  = (cfg_addr == c_addr_vaddr);
   assign w_mapped     = w_sel_region | w_sel_ctrl | w_sel_status | w_sel_vaddr;
   assign w_err        = ~w_mapped
                       | (cfg_write & (w_sel_vaddr | (r_lock & (w_sel_region | w_sel_ctrl))));
   assign w_wr_ok      = cfg_sel & cfg_write & ~w_err;
   assign w_w1c_viol   = w_wr_ok & w_sel_status & cfg_wdata[c_stat_viol];
   assign w_w1c_ovr    = w_wr_ok & w_sel_status & cfg_wdata[c_stat_ovr];
   assign w_viol_eff   = r_viol & ~w_w1c_viol;

   // Read data mux for the addressed register
   always_comb begin
      w_rdata = 32'd0;
      for (int i = 0; i < REGION_NUM; i++) begin
         if (w_ridx == i[2:0]) begin
            if (w_sel_base)  w_rdata = {r_base[i],  {GRAN_LSB{1'b0}}};
            if (w_sel_limit) w_rdata = {r_limit[i], {GRAN_LSB{1'b0}}};
            if (w_sel_attr)  w_rdata = {28'd0, r_attr[i]};
         end
      end
      if (w_sel_ctrl) begin
         w_rdata[c_ctrl_gen]    = r_gen;
         w_rdata[c_ctrl_lock]   = r_lock;
         w_rdata[c_ctrl_int_en] = r_int_en;
      end
      if (w_sel_status) begin
         w_rdata[c_stat_viol]                         = r_viol;
         w_rdata[c_stat_ovr]                          = r_ovr;
         w_rdata[c_stat_vwr]                          = r_vwr;
         w_rdata[c_stat_vidx_lsb+2:c_stat_vidx_lsb]   = r_vidx;
      end
      if (w_sel_vaddr) w_rdata = r_vaddr;
   end

   // Region window registers
   always_ff @(posedge mem_hclk) begin
      if (!mem_hrst_b) begin
         for (int i = 0; i < REGION_NUM; i++) begin
            r_base[i]  <= '0;
            r_limit[i] <= '0;
            r_attr[i]  <= '0;
         end
      end else if (w_wr_ok) begin
         for (int i = 0; i < REGION_NUM; i++) begin
            if (w_ridx == i[2:0]) begin
               if (w_sel_base)  r_base[i]  <= cfg_wdata[31:GRAN_LSB];
               if (w_sel_limit) r_limit[i] <= cfg_wdata[31:GRAN_LSB];
               if (w_sel_attr)  r_attr[i]  <= cfg_wdata[3:0];
            end
         end
      end
   end

   // Global control; LOCK can only be set and is released by reset alone
   always_ff @(posedge mem_hclk) begin
      if (!mem_hrst_b) begin
         r_gen    <= 1'b0;
         r_lock   <= 1'b0;
         r_int_en <= 1'b0;
      end else if (w_wr_ok && w_sel_ctrl) begin
         r_gen    <= cfg_wdata[c_ctrl_gen];
         r_lock   <= r_lock | cfg_wdata[c_ctrl_lock];
         r_int_en <= cfg_wdata[c_ctrl_int_en];
      end
   end

   // Violation capture; a new event beats a same-cycle W1C of VIOL or OVERRUN
   always_ff @(posedge mem_hclk) begin
      if (!mem_hrst_b) begin
         r_viol  <= 1'b0;
         r_ovr   <= 1'b0;
         r_vwr   <= 1'b0;
         r_vidx  <= 3'd0;
         r_vaddr <= 32'd0;
      end else begin
         if (w_viol_ev && !w_viol_eff) begin
            r_viol  <= 1'b1;
            r_vaddr <= mem_haddr;
            r_vwr   <= mem_hwrite;
            r_vidx  <= w_win_idx;
         end else begin
            r_viol  <= w_viol_eff;
         end
         r_ovr <= (r_ovr & ~w_w1c_ovr) | (w_viol_ev & r_viol);
      end
   end

   // Level interrupt follows the registered VIOL gated by INT_EN
   always_ff @(posedge mem_hclk) begin
      if (!mem_hrst_b) r_irq <= 1'b0;
      else             r_irq <= r_viol & r_int_en;
   end

   // One-cycle config response; read data is zero unless a mapped read is acked
   always_ff @(posedge mem_hclk) begin
      if (!mem_hrst_b) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_ack   <= cfg_sel;
         r_err   <= cfg_sel & w_err;
         r_rdata <= (cfg_sel && !cfg_write && w_mapped) ? w_rdata : 32'd0;
      end
   end

   assign cfg_ack   = r_ack;
   assign cfg_err   = r_err;
   assign cfg_rdata = r_rdata;
   assign smu_irq   = r_irq;

endmodule
`default_nettype wire
